// File: rtl/hdmi_pkg.sv
// Shared definitions for the 49-bit HDMI pack bus: field widths, pixel types
// and the per-channel window compare used by colour classifiers.
package hdmi_pkg;

  localparam int PACK_W    = 49;
  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int BOX_CNT_W = 20;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bus layout, MSB first: the pixel clock rides in the top bit.
  typedef struct packed {
    logic           clk;
    logic           hsync;
    logic           vsync;
    logic           de;
    rgb_t           rgb;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pack_t;

  // An inverted window (lo > hi) can never be satisfied, so it matches nothing.
  function automatic logic in_window(input rgb_t lo, input rgb_t hi, input rgb_t c);
    return (c.r >= lo.r) && (c.r <= hi.r) &&
           (c.g >= lo.g) && (c.g <= hi.g) &&
           (c.b >= lo.b) && (c.b <= hi.b);
  endfunction

endpackage

// File: rtl/box_accum.sv
// Per-frame match count and bounding box, cleared and optionally published at
// each frame edge.
module box_accum
  import hdmi_pkg::*;
#(
  parameter int H_ACT      = 1280,
  parameter int V_ACT      = 720,
  parameter int MIN_PIXELS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 match_i,
  input  logic [X_W-1:0]       x_i,
  input  logic [Y_W-1:0]       y_i,
  input  logic                 frame_edge_i,
  input  logic                 armed_i,
  output logic                 box_upd_o,
  output logic                 box_valid_o,
  output logic [X_W-1:0]       box_x0_o,
  output logic [X_W-1:0]       box_x1_o,
  output logic [Y_W-1:0]       box_y0_o,
  output logic [Y_W-1:0]       box_y1_o,
  output logic [BOX_CNT_W-1:0] box_cnt_o
);

  localparam logic [X_W-1:0] XMIN_CLR = X_W'(H_ACT - 1);
  localparam logic [Y_W-1:0] YMIN_CLR = Y_W'(V_ACT - 1);

  logic [BOX_CNT_W-1:0] cnt_q, cnt_d, pcnt_q, pcnt_d;
  logic [X_W-1:0]       xmin_q, xmin_d, xmax_q, xmax_d, px0_q, px0_d, px1_q, px1_d;
  logic [Y_W-1:0]       ymin_q, ymin_d, ymax_q, ymax_d, py0_q, py0_d, py1_q, py1_d;
  logic                 upd_q, upd_d, valid_q, valid_d;

  // The edge clears first, so a coincident match lands in the new frame.
  always_comb begin
    cnt_d  = cnt_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (frame_edge_i) begin
      cnt_d  = '0;
      xmin_d = XMIN_CLR;
      xmax_d = '0;
      ymin_d = YMIN_CLR;
      ymax_d = '0;
    end
    if (match_i) begin
      if (cnt_d != '1) cnt_d = cnt_d + BOX_CNT_W'(1);
      if (x_i < xmin_d) xmin_d = x_i;
      if (x_i > xmax_d) xmax_d = x_i;
      if (y_i < ymin_d) ymin_d = y_i;
      if (y_i > ymax_d) ymax_d = y_i;
    end

    upd_d   = frame_edge_i & armed_i;
    pcnt_d  = pcnt_q;
    valid_d = valid_q;
    px0_d   = px0_q;
    px1_d   = px1_q;
    py0_d   = py0_q;
    py1_d   = py1_q;
    if (upd_d) begin
      pcnt_d  = cnt_q;
      valid_d = (cnt_q >= BOX_CNT_W'(MIN_PIXELS));
      px0_d   = valid_d ? xmin_q : '0;
      px1_d   = valid_d ? xmax_q : '0;
      py0_d   = valid_d ? ymin_q : '0;
      py1_d   = valid_d ? ymax_q : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      xmin_q  <= XMIN_CLR;
      xmax_q  <= '0;
      ymin_q  <= YMIN_CLR;
      ymax_q  <= '0;
      upd_q   <= 1'b0;
      valid_q <= 1'b0;
      pcnt_q  <= '0;
      px0_q   <= '0;
      px1_q   <= '0;
      py0_q   <= '0;
      py1_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      upd_q   <= upd_d;
      valid_q <= valid_d;
      pcnt_q  <= pcnt_d;
      px0_q   <= px0_d;
      px1_q   <= px1_d;
      py0_q   <= py0_d;
      py1_q   <= py1_d;
    end
  end

  assign box_upd_o   = upd_q;
  assign box_valid_o = valid_q;
  assign box_cnt_o   = pcnt_q;
  assign box_x0_o    = px0_q;
  assign box_x1_o    = px1_q;
  assign box_y0_o    = py0_q;
  assign box_y1_o    = py1_q;

endmodule

// File: rtl/delay.sv
// Fixed-depth register delay line with asynchronous clear.
module delay #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/hdmi_pack.sv
// Reassembles clock and video fields into the HDMI pack bus.
module hdmi_pack
  import hdmi_pkg::*;
(
  input  logic              clk_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              de_i,
  input  rgb_t              rgb_i,
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [PACK_W-1:0] pack_o
);

  pack_t p;
  assign p      = '{clk: clk_i, hsync: hsync_i, vsync: vsync_i, de: de_i,
                    rgb: rgb_i, x: x_i, y: y_i};
  assign pack_o = p;

endmodule

// File: rtl/hdmi_unpack.sv
// Splits the HDMI pack bus into its clock and video fields.
module hdmi_unpack
  import hdmi_pkg::*;
(
  input  logic [PACK_W-1:0] pack_i,
  output logic              clk_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              de_o,
  output rgb_t              rgb_o,
  output logic [X_W-1:0]    x_o,
  output logic [Y_W-1:0]    y_o
);

  pack_t p;
  assign p       = pack_t'(pack_i);
  assign clk_o   = p.clk;
  assign hsync_o = p.hsync;
  assign vsync_o = p.vsync;
  assign de_o    = p.de;
  assign rgb_o   = p.rgb;
  assign x_o     = p.x;
  assign y_o     = p.y;

endmodule

// File: rtl/color_box_detect.sv
// Classifies pixels against an RGB window, tracks the matching bounding box per
// frame and optionally draws the last published box onto the passing video.
module color_box_detect
  import hdmi_pkg::*;
#(
  parameter int          H_ACT      = 1280,
  parameter int          V_ACT      = 720,
  parameter int          MIN_PIXELS = 64,
  parameter logic [23:0] BOX_COLOR  = 24'hFF0000
) (
  input  logic [PACK_W-1:0]    i_pack,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 overlay,
  input  logic [23:0]          thr_lo,
  input  logic [23:0]          thr_hi,
  output logic [PACK_W-1:0]    o_pack,
  output logic                 box_upd,
  output logic                 box_valid,
  output logic [X_W-1:0]       box_x0,
  output logic [X_W-1:0]       box_x1,
  output logic [Y_W-1:0]       box_y0,
  output logic [Y_W-1:0]       box_y1,
  output logic [BOX_CNT_W-1:0] box_cnt
);

  localparam int SYNC_W = 3 + X_W + Y_W;

  logic           clk, hs, vs, de;
  rgb_t           rgb;
  logic [X_W-1:0] x, x2;
  logic [Y_W-1:0] y, y2;
  logic           hs2, vs2, de2;
  logic [SYNC_W-1:0] sync_dly;

  hdmi_unpack u_unpack (
    .pack_i(i_pack), .clk_o(clk), .hsync_o(hs), .vsync_o(vs), .de_o(de),
    .rgb_o(rgb), .x_o(x), .y_o(y)
  );

  logic match_d, ovl_d, on_col, on_row;

  // The overlay test uses the undelayed pixel position against the box that
  // is currently published; it only changes at frame edges.
  always_comb begin
    match_d = de & en & in_window(rgb_t'(thr_lo), rgb_t'(thr_hi), rgb);
    on_col  = ((x == box_x0) || (x == box_x1)) && (box_y0 <= y) && (y <= box_y1);
    on_row  = ((y == box_y0) || (y == box_y1)) && (box_x0 <= x) && (x <= box_x1);
    ovl_d   = en & overlay & box_valid & de & (on_col | on_row);
  end

  logic           match_q, ovl_q, vs_q, frame_edge_q, armed_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  rgb_t           rgb1_q, rgb2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q      <= 1'b0;
      ovl_q        <= 1'b0;
      vs_q         <= 1'b0;
      frame_edge_q <= 1'b0;
      armed_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      rgb1_q       <= '0;
      rgb2_q       <= '0;
    end else begin
      match_q      <= match_d;
      ovl_q        <= ovl_d;
      vs_q         <= vs;
      frame_edge_q <= vs & ~vs_q;
      if (frame_edge_q) armed_q <= 1'b1;
      x_q          <= x;
      y_q          <= y;
      rgb1_q       <= rgb;
      rgb2_q       <= ovl_q ? rgb_t'(BOX_COLOR) : rgb1_q;
    end
  end

  box_accum #(.H_ACT(H_ACT), .V_ACT(V_ACT), .MIN_PIXELS(MIN_PIXELS)) u_accum (
    .clk(clk), .rst(rst), .match_i(match_q), .x_i(x_q), .y_i(y_q),
    .frame_edge_i(frame_edge_q), .armed_i(armed_q),
    .box_upd_o(box_upd), .box_valid_o(box_valid),
    .box_x0_o(box_x0), .box_x1_o(box_x1), .box_y0_o(box_y0), .box_y1_o(box_y1),
    .box_cnt_o(box_cnt)
  );

  delay #(.W(SYNC_W), .DEPTH(2)) u_sync_dly (
    .clk(clk), .rst(rst), .d_i({hs, vs, de, x, y}), .q_o(sync_dly)
  );

  assign {hs2, vs2, de2, x2, y2} = sync_dly;

  hdmi_pack u_pack (
    .clk_i(clk), .hsync_i(hs2), .vsync_i(vs2), .de_i(de2),
    .rgb_i(rgb2_q), .x_i(x2), .y_i(y2), .pack_o(o_pack)
  );

endmodule

// File: tb/tb_color_box_detect.sv
// Randomized bench for color_box_detect against a frame-level reference model
// of classification, bounding-box accumulation, publishing and overlay.
module tb_color_box_detect;
  import hdmi_pkg::*;

  localparam logic [23:0] BOXC = 24'hFF0000;
  localparam logic [23:0] GRAY = 24'h969696;
  localparam int MINP = 64;
  localparam int X0 = 290, COLS = 40, Y0 = 45, ROWS = 20;

  typedef struct packed {
    logic hs, vs, de;
    logic [23:0] rgb;
    logic [10:0] x;
    logic [9:0]  y;
  } pix_t;

  typedef struct packed {
    logic upd, valid;
    logic [10:0] x0, x1;
    logic [9:0]  y0, y1;
    logic [19:0] cnt;
  } box_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, overlay;
  logic [23:0] thrLo, thrHi;
  pix_t drv;
  logic [48:0] iPack, oPack;
  logic boxUpd, boxValid;
  logic [10:0] boxX0, boxX1;
  logic [9:0]  boxY0, boxY1;
  logic [19:0] boxCnt;

  assign iPack = {clk, drv};

  color_box_detect dut (
    .i_pack(iPack), .rst(rst), .en(en), .overlay(overlay),
    .thr_lo(thrLo), .thr_hi(thrHi), .o_pack(oPack),
    .box_upd(boxUpd), .box_valid(boxValid),
    .box_x0(boxX0), .box_x1(boxX1), .box_y0(boxY0), .box_y1(boxY1),
    .box_cnt(boxCnt)
  );

  int vectors = 0, miscompares = 0;

  // Reference model state: frame accumulator plus queues giving the two-cycle
  // visibility of both the video and the published results.
  bit   mArmed, mPrevVs;
  int   mCnt, mXmin, mXmax, mYmin, mYmax;
  pix_t outQ[$], rawQ[$];
  box_t boxQ[$];
  pix_t expOut, expRaw;
  box_t expBox;
  bit   sawUpd;
  int   drawn;

  function automatic bit chanOk(input logic [7:0] lo, hi, v);
    return (lo <= v) && (v <= hi);
  endfunction

  function automatic bit pixMatch(input pix_t p);
    return p.de && en &&
           chanOk(thrLo[23:16], thrHi[23:16], p.rgb[23:16]) &&
           chanOk(thrLo[15:8],  thrHi[15:8],  p.rgb[15:8])  &&
           chanOk(thrLo[7:0],   thrHi[7:0],   p.rgb[7:0]);
  endfunction

  task automatic clearFrame();
    mCnt = 0; mXmin = 1279; mYmin = 719; mXmax = 0; mYmax = 0;
  endtask

  task automatic modelReset();
    outQ.delete(); rawQ.delete(); boxQ.delete();
    repeat (2) begin
      outQ.push_back('0); rawQ.push_back('0); boxQ.push_back('0);
    end
    mArmed = 0; mPrevVs = 0;
    clearFrame();
  endtask

  task automatic step(input pix_t p);
    box_t nb, vis;
    pix_t o;
    bit onCol, onRow;
    drv    = p;
    expOut = outQ[0];
    expRaw = rawQ[0];
    expBox = boxQ[0];
    vis    = boxQ[0];
    o      = p;
    onCol  = (p.x == vis.x0 || p.x == vis.x1) && vis.y0 <= p.y && p.y <= vis.y1;
    onRow  = (p.y == vis.y0 || p.y == vis.y1) && vis.x0 <= p.x && p.x <= vis.x1;
    if (en && overlay && vis.valid && p.de && (onCol || onRow)) o.rgb = BOXC;
    outQ.push_back(o);
    rawQ.push_back(p);
    nb = boxQ[$];
    nb.upd = 0;
    if (p.vs && !mPrevVs) begin
      if (mArmed) begin
        nb.upd = 1;
        nb.cnt = 20'(mCnt);
        nb.valid = (mCnt >= MINP);
        nb.x0 = nb.valid ? 11'(mXmin) : '0;
        nb.x1 = nb.valid ? 11'(mXmax) : '0;
        nb.y0 = nb.valid ? 10'(mYmin) : '0;
        nb.y1 = nb.valid ? 10'(mYmax) : '0;
      end
      mArmed = 1;
      clearFrame();
    end
    mPrevVs = p.vs;
    if (pixMatch(p)) begin
      if (mCnt < 20'hFFFFF) mCnt++;
      if (int'(p.x) < mXmin) mXmin = p.x;
      if (int'(p.x) > mXmax) mXmax = p.x;
      if (int'(p.y) < mYmin) mYmin = p.y;
      if (int'(p.y) > mYmax) mYmax = p.y;
    end
    boxQ.push_back(nb);
    void'(outQ.pop_front()); void'(rawQ.pop_front()); void'(boxQ.pop_front());
  endtask

  // Drives one pixel and compares the stream outputs visible in this cycle.
  task automatic runPixel(input pix_t p);
    step(p);
    vectors++;
    if (oPack[47:0] !== expOut) begin
      miscompares++;
      $display("[TB] FAIL stream_pack: got %h want %h", oPack[47:0], expOut);
    end
    vectors++;
    if ({boxUpd, boxValid, boxX0, boxX1, boxY0, boxY1, boxCnt} !== expBox) begin
      miscompares++;
      $display("[TB] FAIL stream_box: got %h want %h",
               {boxUpd, boxValid, boxX0, boxX1, boxY0, boxY1, boxCnt}, expBox);
    end
    if (!en) begin
      vectors++;
      if (oPack[47:0] !== expRaw) begin
        miscompares++;
        $display("[TB] FAIL passthrough: got %h want %h", oPack[47:0], expRaw);
      end
    end
    if (boxUpd) sawUpd = 1;
    if (oPack[45] && oPack[44:21] == BOXC) drawn++;
    @(posedge clk); #1;
  endtask

  task automatic activePhase(input int bx0, bx1, by0, by1, input logic [23:0] color);
    pix_t p;
    for (int yy = 0; yy < ROWS; yy++) begin
      for (int xx = 0; xx < COLS; xx++) begin
        p = '0;
        p.de = 1;
        p.x = 11'(X0 + xx);
        p.y = 10'(Y0 + yy);
        if (X0 + xx >= bx0 && X0 + xx <= bx1 && Y0 + yy >= by0 && Y0 + yy <= by1)
          p.rgb = color;
        else
          p.rgb = {8'($urandom_range(0, 99)), 16'($urandom)};
        runPixel(p);
      end
      repeat (2) begin
        p = '0;
        p.hs = 1;
        runPixel(p);
      end
    end
  endtask

  task automatic vsyncPhase(input bit coinc);
    pix_t p;
    sawUpd = 0;
    for (int i = 0; i < 7; i++) begin
      p = '0;
      p.vs = (i < 4);
      if (i == 0 && coinc) begin
        p.de = 1; p.rgb = GRAY; p.x = 11'd400; p.y = 10'd100;
      end
      runPixel(p);
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 1; overlay = 0;
    thrLo = {3{8'd100}}; thrHi = {3{8'd200}};
    repeat (3) begin
      drv = pix_t'({$urandom, 16'($urandom)});
      @(posedge clk); #1;
    end
    vectors++;
    if (oPack[47:0] !== 48'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_pack: got %h want 0", oPack[47:0]);
    end
    vectors++;
    if ({boxUpd, boxValid, boxX0, boxX1, boxY0, boxY1, boxCnt} !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_box: got %h want 0",
               {boxUpd, boxValid, boxX0, boxX1, boxY0, boxY1, boxCnt});
    end
    drv = '0;
    rst = 0;
    modelReset();
    activePhase(300, 309, 50, 59, GRAY);
    vsyncPhase(0);
    vectors++;
    if (sawUpd !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL first_edge_upd: got %0d want 0", sawUpd);
    end
  endtask

  task automatic test_block10();
    activePhase(300, 309, 50, 59, GRAY);
    vsyncPhase(0);
    vectors++;
    if ({sawUpd, boxValid, boxX0, boxX1, boxY0, boxY1, boxCnt} !==
        {1'b1, 1'b1, 11'd300, 11'd309, 10'd50, 10'd59, 20'd100}) begin
      miscompares++;
      $display("[TB] FAIL block10: got upd=%0d v=%0d x=%0d..%0d y=%0d..%0d cnt=%0d want 1 1 300..309 50..59 100",
               sawUpd, boxValid, boxX0, boxX1, boxY0, boxY1, boxCnt);
    end
  endtask

  task automatic test_small();
    activePhase(300, 304, 50, 54, GRAY);
    vsyncPhase(1);
    vectors++;
    if ({sawUpd, boxValid, boxX0, boxX1, boxY0, boxY1, boxCnt} !==
        {1'b1, 1'b0, 11'd0, 11'd0, 10'd0, 10'd0, 20'd25}) begin
      miscompares++;
      $display("[TB] FAIL small_box: got upd=%0d v=%0d x=%0d..%0d y=%0d..%0d cnt=%0d want 1 0 0..0 0..0 25",
               sawUpd, boxValid, boxX0, boxX1, boxY0, boxY1, boxCnt);
    end
  endtask

  task automatic test_coincident();
    activePhase(1, 0, 1, 0, GRAY);
    vsyncPhase(0);
    vectors++;
    if ({sawUpd, boxValid, boxCnt} !== {1'b1, 1'b0, 20'd1}) begin
      miscompares++;
      $display("[TB] FAIL coincident: got upd=%0d v=%0d cnt=%0d want 1 0 1",
               sawUpd, boxValid, boxCnt);
    end
  endtask

  task automatic test_overlay();
    activePhase(300, 309, 50, 59, GRAY);
    vsyncPhase(0);
    overlay = 1;
    drawn = 0;
    activePhase(300, 309, 50, 59, GRAY);
    vectors++;
    if (drawn !== 36) begin
      miscompares++;
      $display("[TB] FAIL overlay_border: got %0d drawn pixels want 36", drawn);
    end
    vsyncPhase(0);
  endtask

  task automatic test_en_low();
    en = 0;
    drawn = 0;
    activePhase(300, 309, 50, 59, GRAY);
    vectors++;
    if (drawn !== 0) begin
      miscompares++;
      $display("[TB] FAIL en_low_overlay: got %0d drawn pixels want 0", drawn);
    end
    vsyncPhase(0);
    vectors++;
    if ({sawUpd, boxValid, boxX0, boxX1, boxY0, boxY1, boxCnt} !== {1'b1, 1'b0, 62'h0}) begin
      miscompares++;
      $display("[TB] FAIL en_low_publish: got upd=%0d v=%0d cnt=%0d want 1 0 0",
               sawUpd, boxValid, boxCnt);
    end
    en = 1;
  endtask

  task automatic test_random();
    int bx, by, w, h;
    logic [7:0] lo, hi;
    box_t pub;
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < 3; c++) begin
        lo = 8'($urandom_range(0, 200));
        hi = 8'($urandom_range(lo, 255));
        if (f == 3 && c == 1) begin
          thrLo[c*8 +: 8] = hi + 8'd1;
          thrHi[c*8 +: 8] = lo;
        end else begin
          thrLo[c*8 +: 8] = lo;
          thrHi[c*8 +: 8] = hi;
        end
      end
      overlay = 1'($urandom);
      w = $urandom_range(5, 10);
      h = $urandom_range(5, 10);
      bx = X0 + $urandom_range(0, COLS - w);
      by = Y0 + $urandom_range(0, ROWS - h);
      activePhase(bx, bx + w - 1, by, by + h - 1,
                  (f % 2 == 0) ? {thrLo[23:16], thrHi[15:8], thrLo[7:0]} : 24'($urandom));
      vsyncPhase(1'($urandom));
      pub = boxQ[$];
      vectors++;
      if ({sawUpd, boxValid, boxX0, boxX1, boxY0, boxY1, boxCnt} !== {1'b1, pub[62:0]}) begin
        miscompares++;
        $display("[TB] FAIL random_publish[%0d]: got v=%0d cnt=%0d want v=%0d cnt=%0d",
                 f, boxValid, boxCnt, pub.valid, pub.cnt);
      end
    end
    thrLo = {3{8'd100}}; thrHi = {3{8'd200}};
  endtask

  task automatic test_midreset();
    activePhase(300, 309, 50, 59, GRAY);
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({boxUpd, boxValid, boxCnt} !== 22'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_clear: got upd=%0d v=%0d cnt=%0d want 0 0 0",
               boxUpd, boxValid, boxCnt);
    end
    rst = 0;
    modelReset();
    vsyncPhase(0);
    vectors++;
    if (sawUpd !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_first_edge: got upd seen=%0d want 0", sawUpd);
    end
    activePhase(1, 0, 1, 0, GRAY);
    vsyncPhase(0);
    vectors++;
    if ({sawUpd, boxValid, boxCnt} !== {1'b1, 1'b0, 20'd0}) begin
      miscompares++;
      $display("[TB] FAIL midreset_second_edge: got upd=%0d v=%0d cnt=%0d want 1 0 0",
               sawUpd, boxValid, boxCnt);
    end
  endtask

  initial begin
    drv = '0;
    @(posedge clk); #1;
    test_reset();
    test_block10();
    test_small();
    test_coincident();
    test_overlay();
    test_en_low();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/color_box_detect.md
# color_box_detect

Downstream stage of the white-balance stage on the 49-bit HDMI pack bus. The block classifies each active pixel against a programmable per-channel RGB window. Per frame it accumulates the match count and the bounding box of matching pixels, and publishes the result at the next vsync rising edge. It optionally overlays the last published box onto the video, so it feeds both the target-tracking logic and the HDMI output path.

## Interface
Parameters:
- H_ACT, 1280, active width; X_W = $clog2(H_ACT)
- V_ACT, 720, active height; Y_W = $clog2(V_ACT)
- MIN_PIXELS, 64, minimum match count for a box to be declared valid
- BOX_COLOR, 24'hFF0000, overlay colour {r,g,b}

Ports:
- i_pack  in  49  input pack; carries the single clock `clk` (recovered via hdmi_unpack), hsync, vsync, de, r, g, b, x, y
- rst  in  1  reset, asynchronous, active-high
- en  in  1  1 = classify/accumulate and allow overlay; 0 = pure pass-through, published results held
- overlay  in  1  1 = draw published box border into o_pack
- thr_lo  in  24  lower bound {r,g,b}, inclusive
- thr_hi  in  24  upper bound {r,g,b}, inclusive
- o_pack  out  49  output pack, same clock, fixed 2-cycle latency
- box_upd  out  1  single-cycle pulse when results are published
- box_valid  out  1  published count >= MIN_PIXELS
- box_x0, box_x1  out  X_W  published min/max x
- box_y0, box_y1  out  Y_W  published min/max y
- box_cnt  out  20  published match count

## Operation
- Match: de & en & (thr_lo.c <= c <= thr_hi.c) for each of r, g, b. Comparisons are unsigned. If thr_lo > thr_hi on any channel, nothing matches.
- Accumulators: cnt (20 b, saturating at all-ones), xmin/xmax/ymin/ymax.
  - Clear values: xmin = H_ACT-1, ymin = V_ACT-1, xmax = ymax = 0, cnt = 0.
  - Each match increments cnt. xmin/xmax/ymin/ymax are updated with min/max of the pixel's x and y.
- Frame edge: vsync rising edge, detected from a registered vsync.
  - On the edge, accumulators clear.
  - If `armed`, publish: box_cnt = cnt. If cnt >= MIN_PIXELS, the box regs take the accumulator values and box_valid = 1. Otherwise the box regs are zero and box_valid = 0. box_upd pulses for one cycle.
  - `armed` is cleared by reset and set on the first frame edge. The first edge after reset clears without publishing, so a partial frame is never published.
- Simultaneous edge + match: the edge has priority. The coincident matching pixel is counted into the new frame, on top of the cleared values.
- en = 0: no accumulation. Frame edges still clear and publish, so a frame with en low publishes cnt = 0 and box_valid = 0. o_pack equals i_pack delayed by 2 cycles.
- Overlay: a pixel is drawn as BOX_COLOR when en & overlay & box_valid & de and either condition holds:
  - (x == box_x0 or x == box_x1) and box_y0 <= y <= box_y1, or
  - (y == box_y0 or y == box_y1) and box_x0 <= x <= box_x1.
  - The test uses the pixel's own x/y, before the delay.
- Published values change only at a frame edge, so the box drawn within a frame is constant for that frame.

## Timing
- o_pack: hsync, vsync, de, x, y and rgb are delayed exactly 2 clk cycles through the delay module. The overlay mux result is registered into the rgb path in stage 2.
- Pipeline:
  - Stage 1 registers the match flag, x, y and the vsync edge.
  - Accumulators update at the end of stage 1.
  - box_* and box_upd update on the cycle after the edge is detected, i.e. 2 cycles after vsync rises at i_pack.
- Reset (async assert, sync release by the caller) clears:
  - all box_* outputs, box_upd and `armed` to 0;
  - the accumulators to their clear values;
  - the pipeline registers, so o_pack sync/de/rgb/x/y are 0.
- Reset mid-frame: the partial frame is discarded via `armed`.

## Structure
- Shared package `hdmi_pkg`: PACK_W = 49, X_W = 11, Y_W = 10, typedef rgb_t {r,g,b} 8 b each, BOX_CNT_W = 20.
- Reuses hdmi_unpack, hdmi_pack and delay.
- One sub-module: `box_accum`. It holds the clear/min/max/count/publish logic with inputs match, x, y, edge and armed. The top holds classification, overlay and the delay chains.

## Test plan
- Reset held, then released mid-frame with matching pixels → first vsync edge gives no box_upd; second edge gives box_upd with correct values.
- thr = [100,200] on all channels; one frame with a 10×10 block of rgb 150 at x 300..309, y 50..59 → box_x0 = 300, box_x1 = 309, box_y0 = 50, box_y1 = 59, box_cnt = 100, box_valid = 1.
- Same stimulus with a 5×5 block (cnt 25 < 64) → box_valid = 0, box_x*/y* = 0, box_cnt = 25.
- Next frame after a valid box with overlay = 1 → o_pack rgb = FF0000 exactly on border pixels, all other pixels equal to i_pack delayed 2 cycles; sync and de are 2-cycle delayed copies.
- en = 0 for a full frame → o_pack bit-exact to i_pack delayed 2 cycles; publish gives box_cnt = 0, box_valid = 0.
- Match asserted in the same cycle as the vsync rising edge → that pixel appears in the next frame's count, not in the published one.
